// File: rtl/pong_game_if.sv
// pong_game_if: event/control bundle between the pong ball/paddle datapath and the game controller.
interface pong_game_if #(parameter int SCORE_W = 4);
    logic               frame_tick, start, pause, miss_left, miss_right;
    logic               ball_run, ball_recenter, serve_dir, title_on, game_over, winner;
    logic [SCORE_W-1:0] score1, score2;
    modport master (
        output frame_tick, start, pause, miss_left, miss_right,
        input  ball_run, ball_recenter, serve_dir, score1, score2, title_on, game_over, winner
    );
    modport slave (
        input  frame_tick, start, pause, miss_left, miss_right,
        output ball_run, ball_recenter, serve_dir, score1, score2, title_on, game_over, winner
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game-flow sequencer (title, serve, play, point pause, game over) owning all scoring.
// Define PAUSE_EN to add a PAUSED state toggled by pause-button rising edges while in PLAY.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int SCORE_W      = 4,
    parameter int CNT_W        = 8
) (
    input logic        clk,
    input logic        reset,
    pong_game_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SERVE, PLAY, POINT, OVER
`ifdef PAUSE_EN
        , PAUSED
`endif
    } state_t;
    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [SCORE_W-1:0] score1, score2, score1_d, score2_d;
    logic               serve_dir, serve_dir_d, winner, winner_d, start_q;
    logic               ball_run, ball_recenter, title_on, game_over;
    logic               run_d, recenter_d, title_d, over_d;
    logic               start_edge, serve_done, point_done, pause_edge;
    assign start_edge = bus.start & ~start_q;
    assign serve_done = bus.frame_tick && cnt == CNT_W'(SERVE_FRAMES - 1);
    assign point_done = bus.frame_tick && cnt == CNT_W'(POINT_FRAMES - 1);
`ifdef PAUSE_EN
    logic pause_q;
    assign pause_edge = bus.pause & ~pause_q;
    // Reset high like start_q so a button held through reset is not seen as a press.
    always_ff @(posedge clk or posedge reset)
        if (reset) pause_q <= 1'b1;
        else pause_q <= bus.pause;
`else
    assign pause_edge = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            score1        <= '0;
            score2        <= '0;
            serve_dir     <= 1'b1;
            winner        <= 1'b0;
            start_q       <= 1'b1;
            ball_run      <= 1'b0;
            ball_recenter <= 1'b1;
            title_on      <= 1'b1;
            game_over     <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            score1        <= score1_d;
            score2        <= score2_d;
            serve_dir     <= serve_dir_d;
            winner        <= winner_d;
            start_q       <= bus.start;
            ball_run      <= run_d;
            ball_recenter <= recenter_d;
            title_on      <= title_d;
            game_over     <= over_d;
        end
    always_comb begin
        state_d     = state;
        score1_d    = score1;
        score2_d    = score2;
        serve_dir_d = serve_dir;
        winner_d    = winner;
        case (state)
            IDLE, OVER: if (start_edge) begin
                score1_d    = '0;
                score2_d    = '0;
                serve_dir_d = (state == IDLE) ? 1'b1 : ~winner;
                state_d     = SERVE;
            end
            SERVE: state_d = serve_done ? PLAY : SERVE;
            POINT: state_d = point_done ? SERVE : POINT;
            // Simultaneous misses are a wash: no score, serve direction kept.
            PLAY: if (bus.miss_left && bus.miss_right) state_d = POINT;
            else if (bus.miss_left) begin
                score2_d    = score2 + SCORE_W'(1);
                serve_dir_d = 1'b0;
                winner_d    = (score2_d == SCORE_W'(WIN_SCORE)) ? 1'b1 : winner;
                state_d     = (score2_d == SCORE_W'(WIN_SCORE)) ? OVER : POINT;
            end else if (bus.miss_right) begin
                score1_d    = score1 + SCORE_W'(1);
                serve_dir_d = 1'b1;
                winner_d    = (score1_d == SCORE_W'(WIN_SCORE)) ? 1'b0 : winner;
                state_d     = (score1_d == SCORE_W'(WIN_SCORE)) ? OVER : POINT;
            end
`ifdef PAUSE_EN
            else if (pause_edge) state_d = PAUSED;
            PAUSED: state_d = pause_edge ? PLAY : PAUSED;
`endif
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        cnt_d      = (state_d != state || !(state inside {SERVE, POINT})) ? '0 : cnt + CNT_W'(bus.frame_tick);
        run_d      = state_d == PLAY;
        recenter_d = state_d inside {IDLE, SERVE, OVER};
        title_d    = state_d == IDLE;
        over_d     = state_d == OVER;
    end
    assign bus.ball_run      = ball_run;
    assign bus.ball_recenter = ball_recenter;
    assign bus.serve_dir     = serve_dir;
    assign bus.score1        = score1;
    assign bus.score2        = score2;
    assign bus.title_on      = title_on;
    assign bus.game_over     = game_over;
    assign bus.winner        = winner;
endmodule
